// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the program-loader slice.
//   XLEN           : instruction / data word width
//   loader_state_t : loader FSM states
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        HOLD
    } loader_state_t;

endpackage : riscv_pkg

// File: rtl/riscv_byte_packer.sv
// -----------------------------------------------------------------------------
// riscv_byte_packer
//   Packs a byte stream into little-endian XLEN-bit words. The first byte of a
//   word lands in [7:0]. o_word_vld/o_word are combinational and present the
//   completed word in the same cycle its last byte is accepted.
// Ports
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_flush           : discard any partial word and restart at lane 0
//   i_byte_vld        : a byte is accepted this cycle
//   i_byte            : byte data
//   o_word_vld        : the accepted byte completes a word
//   o_word            : completed word (valid with o_word_vld)
// -----------------------------------------------------------------------------
module riscv_byte_packer
    import riscv_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_byte_vld,
    input  logic [7:0]      i_byte,
    output logic            o_word_vld,
    output logic [XLEN-1:0] o_word
);

    logic [1:0]      r_lane;
    logic [XLEN-9:0] r_asm;   // lower three bytes; the top byte comes straight from i_byte

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lane <= '0;
            r_asm  <= '0;
        end else if (i_flush) begin
            r_lane <= '0;
            r_asm  <= '0;
        end else if (i_byte_vld) begin
            r_lane <= r_lane + 2'd1;
            case (r_lane)
                2'd0:    r_asm[7:0]   <= i_byte;
                2'd1:    r_asm[15:8]  <= i_byte;
                2'd2:    r_asm[23:16] <= i_byte;
                default: ;
            endcase
        end
    end

    assign o_word_vld = i_byte_vld && (r_lane == 2'd3);
    assign o_word     = {i_byte, r_asm};

endmodule : riscv_byte_packer

// File: rtl/riscv_prog_loader.sv
// -----------------------------------------------------------------------------
// riscv_prog_loader
//   Boot stage for the single-cycle core: receives a byte stream, packs it into
//   little-endian 32-bit words, writes them to instruction memory and holds the
//   core in reset until the program is loaded. All outputs are registered.
// Ports
//   clk, srst   : clock, asynchronous active-high reset
//   start       : 1-cycle pulse, begin a load (len_words sampled here)
//   len_words   : program length in words
//   abort       : cancel a load in progress
//   s_valid/s_data/s_ready : byte stream handshake
//   imem_we/imem_waddr/imem_wdata : instruction memory write port
//   core_srst   : reset to the core
//   busy        : load in progress
//   done / err  : sticky status, cleared by the next accepted start
//   checksum    : sum of written words mod 2**32
// -----------------------------------------------------------------------------
module riscv_prog_loader
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned RST_HOLD  = 2
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic [ADDR_W:0]   len_words,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              core_srst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [XLEN-1:0]   checksum
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    // A zero hold length behaves as a single hold cycle.
    localparam int unsigned HOLD_LAST = (RST_HOLD == 0) ? 0 : RST_HOLD - 1;
    localparam int unsigned HOLD_W    = $clog2(HOLD_LAST + 1) + 1;

    loader_state_t     r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_len, w_len_nxt;
    logic [CNT_W-1:0]  r_word_cnt, w_word_cnt_nxt;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic              r_s_ready, w_s_ready_nxt;
    logic              r_imem_we, w_imem_we_nxt;
    logic [ADDR_W-1:0] r_imem_waddr, w_imem_waddr_nxt;
    logic [XLEN-1:0]   r_imem_wdata, w_imem_wdata_nxt;
    logic              r_core_srst, w_core_srst_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic [XLEN-1:0]   r_checksum, w_checksum_nxt;

    logic              w_flush;
    logic              w_byte_fire;
    logic              w_word_vld;
    logic [XLEN-1:0]   w_word;

    assign w_byte_fire = s_valid && r_s_ready && (r_state == RECV);

    riscv_byte_packer u_packer (
        .i_clk      (clk),
        .i_rst      (srst),
        .i_flush    (w_flush),
        .i_byte_vld (w_byte_fire),
        .i_byte     (s_data),
        .o_word_vld (w_word_vld),
        .o_word     (w_word)
    );

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_len        <= '0;
            r_word_cnt   <= '0;
            r_hold_cnt   <= '0;
            r_s_ready    <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= '0;
            r_core_srst  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_checksum   <= '0;
        end else begin
            r_len        <= w_len_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_s_ready    <= w_s_ready_nxt;
            r_imem_we    <= w_imem_we_nxt;
            r_imem_waddr <= w_imem_waddr_nxt;
            r_imem_wdata <= w_imem_wdata_nxt;
            r_core_srst  <= w_core_srst_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_checksum   <= w_checksum_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_len_nxt        = r_len;
        w_word_cnt_nxt   = r_word_cnt;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_s_ready_nxt    = r_s_ready;
        w_imem_we_nxt    = 1'b0;
        w_imem_waddr_nxt = r_imem_waddr;
        w_imem_wdata_nxt = r_imem_wdata;
        w_core_srst_nxt  = r_core_srst;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;
        w_err_nxt        = r_err;
        w_checksum_nxt   = r_checksum;
        w_flush          = 1'b0;

        case (r_state)
            IDLE: begin
                // abort is ignored here; only start matters
                if (start) begin
                    if ((len_words == '0) || (len_words > CNT_W'(MAX_WORDS))) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = RECV;
                        w_len_nxt       = len_words;
                        w_word_cnt_nxt  = '0;
                        w_checksum_nxt  = '0;
                        w_done_nxt      = 1'b0;
                        w_err_nxt       = 1'b0;
                        w_busy_nxt      = 1'b1;
                        w_core_srst_nxt = 1'b1;
                        w_s_ready_nxt   = 1'b1;
                        w_flush         = 1'b1;
                    end
                end
            end
            RECV: begin
                if (abort) begin
                    // the word that might complete this cycle is never written
                    w_state_nxt   = IDLE;
                    w_err_nxt     = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_s_ready_nxt = 1'b0;
                    w_flush       = 1'b1;
                end else if (w_word_vld) begin
                    w_state_nxt      = WRITE;
                    w_imem_we_nxt    = 1'b1;
                    w_imem_waddr_nxt = r_word_cnt[ADDR_W-1:0];
                    w_imem_wdata_nxt = w_word;
                    w_s_ready_nxt    = 1'b0;
                end
            end
            WRITE: begin
                if (abort) begin
                    w_state_nxt   = IDLE;
                    w_err_nxt     = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_s_ready_nxt = 1'b0;
                    w_flush       = 1'b1;
                end else begin
                    w_checksum_nxt = r_checksum + r_imem_wdata;
                    w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
                    if (r_word_cnt == r_len - CNT_W'(1)) begin
                        w_state_nxt    = HOLD;
                        w_hold_cnt_nxt = '0;
                    end else begin
                        w_state_nxt   = RECV;
                        w_s_ready_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (r_hold_cnt == HOLD_W'(HOLD_LAST)) begin
                    w_state_nxt     = IDLE;
                    w_core_srst_nxt = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_busy_nxt      = 1'b0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign s_ready    = r_s_ready;
    assign imem_we    = r_imem_we;
    assign imem_waddr = r_imem_waddr;
    assign imem_wdata = r_imem_wdata;
    assign core_srst  = r_core_srst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign checksum   = r_checksum;

endmodule : riscv_prog_loader

// File: tb/tb_riscv_prog_loader.sv
module tb_riscv_prog_loader;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned MAX_WORDS = 1024;
    localparam int unsigned RST_HOLD  = 2;

    logic              clk = 1'b0;
    logic              srst;
    logic              start;
    logic [ADDR_W:0]   len_words;
    logic              abort;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_srst;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       checksum;

    int errors = 0;
    int checks = 0;

    riscv_prog_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS),
        .RST_HOLD  (RST_HOLD)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .start      (start),
        .len_words  (len_words),
        .abort      (abort),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_srst  (core_srst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Write log and timing monitor, sampled on the falling edge.
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int cyc = 0;
    int last_we_cyc = 0;
    int fall_cyc = 0;
    int ready_in_write = 0;
    logic prev_srst = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (imem_we === 1'b1) begin
                wr_addr.push_back(imem_waddr);
                wr_data.push_back(imem_wdata);
                last_we_cyc = cyc;
                if (s_ready !== 1'b0) ready_in_write = ready_in_write + 1;
            end
            if (prev_srst === 1'b1 && core_srst === 1'b0) fall_cyc = cyc;
            prev_srst = core_srst;
        end
    end

    logic [7:0] prog2 [8] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'ha0, 8'h00};

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        ready_in_write = 0;
    endtask

    task automatic do_start(input logic [ADDR_W:0] len);
        @(negedge clk);
        start     = 1'b1;
        len_words = len;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit sent = 0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 20; i++) begin
            if (s_ready === 1'b1) begin
                @(negedge clk);
                sent = 1;
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++;
        if (!sent) begin
            errors++;
            $display("FAIL byte_accept: byte %h not accepted within 20 cycles", b);
        end
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_done: done still %b after %0d cycles", done, budget);
        end
    endtask

    task automatic check_prog2(input string tag);
        checks++;
        if (wr_addr.size() !== 2) begin
            errors++;
            $display("FAIL %s_nwrites: got %0d exp 2", tag, wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h00500513) begin
                errors++;
                $display("FAIL %s_w0: got [%0d]=%h exp [0]=00500513", tag, wr_addr[0], wr_data[0]);
            end
            checks++;
            if (wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h00a00593) begin
                errors++;
                $display("FAIL %s_w1: got [%0d]=%h exp [1]=00a00593", tag, wr_addr[1], wr_data[1]);
            end
        end
        checks++;
        if (checksum !== 32'h00F00AA6) begin
            errors++;
            $display("FAIL %s_checksum: got %h exp 00f00aa6", tag, checksum);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || core_srst !== 1'b0) begin
            errors++;
            $display("FAIL %s_status: got done=%b busy=%b err=%b core_srst=%b exp 1 0 0 0",
                     tag, done, busy, err, core_srst);
        end
    endtask

    task automatic test_reset();
        srst = 1'b1; start = 1'b0; len_words = '0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        #1;
        checks++;
        if (core_srst !== 1'b1) begin
            errors++;
            $display("FAIL reset_core_srst: got %b exp 1", core_srst);
        end
        checks++;
        if ({s_ready, imem_we, busy, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got s_ready/we/busy/done/err=%b exp 00000",
                     {s_ready, imem_we, busy, done, err});
        end
        checks++;
        if (checksum !== 32'h0) begin
            errors++;
            $display("FAIL reset_checksum: got %h exp 0", checksum);
        end
        repeat (2) @(negedge clk);
        srst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (core_srst !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got core_srst=%b busy=%b exp 1 0", core_srst, busy);
        end
    endtask

    task automatic test_basic_load();
        clear_log();
        do_start(2);
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1 || core_srst !== 1'b1) begin
            errors++;
            $display("FAIL basic_after_start: got busy=%b s_ready=%b core_srst=%b exp 1 1 1",
                     busy, s_ready, core_srst);
        end
        for (int i = 0; i < 8; i++) send_byte(prog2[i], 0);
        wait_done(40);
        check_prog2("basic");
        // core_srst is high for RST_HOLD sampled cycles after the write cycle
        checks++;
        if (fall_cyc - last_we_cyc !== RST_HOLD + 1) begin
            errors++;
            $display("FAIL basic_hold: got fall-we=%0d exp %0d", fall_cyc - last_we_cyc, RST_HOLD + 1);
        end
    endtask

    task automatic test_gaps();
        clear_log();
        do_start(2);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL gaps_done_cleared: got %b exp 0", done);
        end
        for (int i = 0; i < 8; i++) send_byte(prog2[i], int'($urandom_range(0, 3)));
        wait_done(40);
        check_prog2("gaps");
        checks++;
        if (ready_in_write !== 0) begin
            errors++;
            $display("FAIL gaps_ready_in_write: got %0d cycles exp 0", ready_in_write);
        end
        checks++;
        if (fall_cyc - last_we_cyc !== RST_HOLD + 1) begin
            errors++;
            $display("FAIL gaps_hold: got fall-we=%0d exp %0d", fall_cyc - last_we_cyc, RST_HOLD + 1);
        end
    endtask

    task automatic test_bad_len();
        logic [ADDR_W:0] bad [2];
        bad[0] = '0;
        bad[1] = (ADDR_W + 1)'(MAX_WORDS + 1);
        for (int k = 0; k < 2; k++) begin
            clear_log();
            do_start(bad[k]);
            repeat (4) @(negedge clk);
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL bad_len_%0d: got err=%b busy=%b s_ready=%b exp 1 0 0",
                         bad[k], err, busy, s_ready);
            end
            checks++;
            if (wr_addr.size() !== 0) begin
                errors++;
                $display("FAIL bad_len_%0d_writes: got %0d exp 0", bad[k], wr_addr.size());
            end
        end
    endtask

    task automatic test_abort();
        clear_log();
        do_start(2);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_start: got err=%b busy=%b exp 0 1", err, busy);
        end
        send_byte(prog2[0], 0);
        send_byte(prog2[1], 0);
        // start while busy must not restart the load
        start = 1'b1; len_words = 1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 2; i < 5; i++) send_byte(prog2[i], 0);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: got %b exp 1", busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr.size() !== 1) begin
            errors++;
            $display("FAIL abort_nwrites: got %0d exp 1", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h00500513) begin
                errors++;
                $display("FAIL abort_w0: got [%0d]=%h exp [0]=00500513", wr_addr[0], wr_data[0]);
            end
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || core_srst !== 1'b1 || done !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_status: got err=%b busy=%b core_srst=%b done=%b s_ready=%b exp 1 0 1 0 0",
                     err, busy, core_srst, done, s_ready);
        end
        clear_log();
        do_start(2);
        for (int i = 0; i < 8; i++) send_byte(prog2[i], 0);
        wait_done(40);
        check_prog2("reload");
    endtask

    task automatic test_reset_midload();
        clear_log();
        do_start(2);
        send_byte(prog2[0], 0);
        send_byte(prog2[1], 0);
        #2 srst = 1'b1;
        #1;
        checks++;
        if (core_srst !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || checksum !== 32'h0) begin
            errors++;
            $display("FAIL midreset: got core_srst=%b busy=%b s_ready=%b done=%b err=%b cs=%h exp 1 0 0 0 0 0",
                     core_srst, busy, s_ready, done, err, checksum);
        end
        @(negedge clk);
        srst = 1'b0;
        clear_log();
        do_start(1);
        send_byte(8'h6f, 0);
        send_byte(8'h00, 1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 2);
        wait_done(40);
        checks++;
        if (wr_addr.size() !== 1) begin
            errors++;
            $display("FAIL postreset_nwrites: got %0d exp 1", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h0000006f) begin
                errors++;
                $display("FAIL postreset_w0: got [%0d]=%h exp [0]=0000006f", wr_addr[0], wr_data[0]);
            end
        end
        checks++;
        if (checksum !== 32'h0000006f || done !== 1'b1 || core_srst !== 1'b0) begin
            errors++;
            $display("FAIL postreset_status: got cs=%h done=%b core_srst=%b exp 0000006f 1 0",
                     checksum, done, core_srst);
        end
    endtask

    // Largest legal program: word i holds the value i, so checksum = sum(0..1023).
    task automatic test_max_len();
        int bad_words = 0;
        logic [15:0] v;
        clear_log();
        do_start((ADDR_W + 1)'(MAX_WORDS));
        for (int w = 0; w < int'(MAX_WORDS); w++) begin
            v = 16'(w);
            send_byte(v[7:0], 0);
            send_byte(v[15:8], 0);
            send_byte(8'h00, 0);
            send_byte(8'h00, 0);
        end
        wait_done(40);
        checks++;
        if (wr_addr.size() !== int'(MAX_WORDS)) begin
            errors++;
            $display("FAIL max_nwrites: got %0d exp %0d", wr_addr.size(), MAX_WORDS);
        end else begin
            for (int w = 0; w < int'(MAX_WORDS); w++)
                if (wr_addr[w] !== ADDR_W'(w) || wr_data[w] !== 32'(w)) bad_words++;
            checks++;
            if (bad_words !== 0) begin
                errors++;
                $display("FAIL max_words: got %0d bad addr/data pairs exp 0", bad_words);
            end
        end
        checks++;
        if (checksum !== 32'h0007FE00 || done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL max_status: got cs=%h done=%b err=%b exp 0007fe00 1 0", checksum, done, err);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_gaps();
        test_bad_len();
        test_abort();
        test_reset_midload();
        test_max_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_riscv_prog_loader
